// File: rtl/stage_seq_pkg.sv
// Shared definitions for the stage sequencer: state encoding and width helpers.
package stage_seq_pkg;

  // Round controller states, 3-bit encoding.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_SHOW      = 3'd1;
  localparam state_t ST_WAIT_KEY  = 3'd2;
  localparam state_t ST_CHECK     = 3'd3;
  localparam state_t ST_DONE_PASS = 3'd4;
  localparam state_t ST_DONE_FAIL = 3'd5;

  // Bits needed to index n stage entries (at least one bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold a score from 0 up to n inclusive.
  function automatic int score_w(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed by a down-counter loaded with max(a, b) - 1.
  function automatic int timer_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/stage_timer.sv
// Loadable down-counter with a zero flag; one instance times both the
// display window and the key-wait window.
module stage_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/stage_sequencer.sv
// Game-round controller: presents each stage entry for a fixed window, waits
// for the player's key, scores it, and ends the round on pass, miss or timeout.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter  int NUM_STAGES     = 5,
  parameter  int DATA_W         = 2,
  parameter  int SHOW_CYCLES    = 50,
  parameter  int TIMEOUT_CYCLES = 1000,
  localparam int IDX_W          = idx_w(NUM_STAGES),
  localparam int SCORE_W        = score_w(NUM_STAGES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_table,
  input  logic                         key_valid,
  input  logic [DATA_W-1:0]            key_data,
  output logic [IDX_W-1:0]             stage_idx,
  output logic                         show_valid,
  output logic [DATA_W-1:0]            show_data,
  output logic                         busy,
  output logic                         pass,
  output logic                         fail,
  output logic [SCORE_W-1:0]           score
);

  localparam int                 TMR_W        = timer_w(SHOW_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0]   SHOW_LOAD    = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_STAGES - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [IDX_W-1:0]    r_idx;
  logic [SCORE_W-1:0]  r_score;
  logic [DATA_W-1:0]   r_key;
  logic [DATA_W-1:0]   w_entry;
  logic                w_hit;
  logic                w_timer_load;
  logic [TMR_W-1:0]    w_timer_val;
  logic                w_timer_zero;
  logic                w_round_clr;
  logic                w_key_latch;
  logic                w_score_inc;
  logic                w_idx_inc;

  stage_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_val),
    .o_zero     (w_timer_zero)
  );

  // Select the entry for the current stage straight from the live table.
  always_comb begin
    w_entry = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_entry = stage_table[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_hit = (r_key == w_entry);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values, independent of block order.
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the datapath strobes that accompany each transition.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    w_state_next = r_state;
    w_timer_load = 1'b0;
    w_timer_val  = SHOW_LOAD;
    w_round_clr  = 1'b0;
    w_key_latch  = 1'b0;
    w_score_inc  = 1'b0;
    w_idx_inc    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE_PASS, ST_DONE_FAIL: begin
        if (start) begin
          w_state_next = ST_SHOW;
          w_timer_load = 1'b1;
          w_round_clr  = 1'b1;
        end
      end
      ST_SHOW: begin
        if (w_timer_zero) begin
          w_state_next = ST_WAIT_KEY;
          w_timer_load = 1'b1;
          w_timer_val  = TIMEOUT_LOAD;
        end
      end
      ST_WAIT_KEY: begin
        // A key on the last timer cycle still counts as an answer.
        if (key_valid) begin
          w_key_latch  = 1'b1;
          w_state_next = ST_CHECK;
        end else if (w_timer_zero) begin
          w_state_next = ST_DONE_FAIL;
        end
      end
      ST_CHECK: begin
        if (w_hit) begin
          w_score_inc = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_next = ST_DONE_PASS;
          end else begin
            w_idx_inc    = 1'b1;
            w_state_next = ST_SHOW;
            w_timer_load = 1'b1;
          end
        end else begin
          w_state_next = ST_DONE_FAIL;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Stage index, score and latched key.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= '0;
      r_score <= '0;
      r_key   <= '0;
    end else begin
      if (w_round_clr) begin
        r_idx   <= '0;
        r_score <= '0;
      end else begin
        if (w_idx_inc) begin
          r_idx <= r_idx + IDX_W'(1);
        end
        if (w_score_inc) begin
          r_score <= r_score + SCORE_W'(1);
        end
      end
      if (w_key_latch) begin
        r_key <= key_data;
      end
    end
  end

  // Outputs decoded from state; show_data is forced to zero outside SHOW.
  always_comb begin
    show_valid = (r_state == ST_SHOW);
    busy       = (r_state == ST_SHOW) || (r_state == ST_WAIT_KEY) || (r_state == ST_CHECK);
    pass       = (r_state == ST_DONE_PASS);
    fail       = (r_state == ST_DONE_FAIL);
    show_data  = (r_state == ST_SHOW) ? w_entry : '0;
  end

  assign stage_idx = r_idx;
  assign score     = r_score;

endmodule
